// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz VGA timing defaults, coordinate type and sync decode helpers shared by the sync generator.
package vga_timing_pkg;

  localparam int COORD_W     = 10;
  localparam int FRAME_CNT_W = 8;

  typedef logic [COORD_W-1:0]     coord_t;
  typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_CLK_DIV   = 2;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Registered per-pixel qualifiers; sync levels are active low.
  typedef struct packed {
    logic video_on;
    logic hsync;
    logic vsync;
  } sync_t;

  localparam sync_t SYNC_RST = '{video_on: 1'b0, hsync: 1'b1, vsync: 1'b1};

  function automatic logic in_window(coord_t c, int lo, int hi);
    return (int'(c) >= lo) && (int'(c) <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Pixel-coordinate interface between the VGA sync generator (master) and its consumers (slave).
// frame_cnt is present only when VGA_FRAME_CNT_EN is defined.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   p_tick;
  coord_t x;
  coord_t y;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   frame_start;

`ifdef VGA_FRAME_CNT_EN
  frame_cnt_t frame_cnt;

  modport master (
    output p_tick, x, y, video_on, hsync, vsync, frame_start, frame_cnt
  );
  modport slave (
    input p_tick, x, y, video_on, hsync, vsync, frame_start, frame_cnt
  );
`else
  modport master (
    output p_tick, x, y, video_on, hsync, vsync, frame_start
  );
  modport slave (
    input p_tick, x, y, video_on, hsync, vsync, frame_start
  );
`endif

endinterface

// File: rtl/vga_sync_gen_tick.sv
// Pixel-rate enable: p_tick is high for one clk out of every CLK_DIV, registered so it is low in reset.
// Latency: first p_tick one clk after reset release; no backpressure (free-running).
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;

  always_comb begin
    div_nxt = div + DIV_W'(1);
    if (div == DIV_LAST) begin
      div_nxt = '0;
    end
  end

  // p_tick tracks (div == DIV_LAST) but stays low during reset even when CLK_DIV is 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      div    <= '0;
      p_tick <= 1'b0;
    end else begin
      div    <= div_nxt;
      p_tick <= (div_nxt == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: h/v pixel counters, registered sync/video_on decode and frame markers (frame_cnt with VGA_FRAME_CNT_EN).
// Latency: all qualifiers line up with x/y in the same clk; no backpressure (free-running).
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  // Both totals must stay below 2**COORD_W.
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  localparam int HS_LO = H_DISPLAY + H_FRONT;
  localparam int HS_HI = HS_LO + H_SYNC - 1;
  localparam int VS_LO = V_DISPLAY + V_FRONT;
  localparam int VS_HI = VS_LO + V_SYNC - 1;

  logic   p_tick;
  coord_t h;
  coord_t v;
  coord_t h_nxt;
  coord_t v_nxt;
  logic   frame_wrap;
  sync_t  sync_q;
  sync_t  sync_nxt;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  always_comb begin
    h_nxt      = h;
    v_nxt      = v;
    frame_wrap = 1'b0;
    if (p_tick) begin
      if (h == H_LAST) begin
        h_nxt = '0;
        if (v == V_LAST) begin
          v_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          v_nxt = v + coord_t'(1);
        end
      end else begin
        h_nxt = h + coord_t'(1);
      end
    end
  end

  // Decoding the next-state counters lets the registered qualifiers land with the new x/y.
  always_comb begin
    sync_nxt          = SYNC_RST;
    sync_nxt.video_on = (int'(h_nxt) < H_DISPLAY) && (int'(v_nxt) < V_DISPLAY);
    sync_nxt.hsync    = !in_window(h_nxt, HS_LO, HS_HI);
    sync_nxt.vsync    = !in_window(v_nxt, VS_LO, VS_HI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h      <= '0;
      v      <= '0;
      sync_q <= SYNC_RST;
    end else begin
      h      <= h_nxt;
      v      <= v_nxt;
      sync_q <= sync_nxt;
    end
  end

  assign vga.p_tick      = p_tick;
  assign vga.x           = h;
  assign vga.y           = v;
  assign vga.video_on    = sync_q.video_on;
  assign vga.hsync       = sync_q.hsync;
  assign vga.vsync       = sync_q.vsync;
  assign vga.frame_start = p_tick && (h == '0) && (v == '0);

`ifdef VGA_FRAME_CNT_EN
  frame_cnt_t frame_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + frame_cnt_t'(1);
    end
  end

  assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule
